// File: rtl/step_controller_pkg.sv
// step_controller_pkg
//   Shared types and constants for the step controller and its key debouncer.
//   - db_state_t : debounce FSM state encoding (also driven onto the db_state debug port)
//   - DIV_W      : width of the free-run divider (holds up to 2^24-1)
//   - RATE_LOG2  : free-run period exponent per rate_sel code (00 -> 2^24 ... 11 -> 2^4)
//   - db_cycles  : debounce window in clk cycles, never less than 1
//   - rate_last  : last divider value of a period (period-1) for a rate_sel code
package step_controller_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } db_state_t;

    localparam int DIV_W = 24;

    localparam int RATE_LOG2 [4] = '{24, 20, 16, 4};

    function automatic int db_cycles(input int clk_hz, input int ms);
        int cycles;
        cycles = clk_hz / 1000 * ms;
        return (cycles < 1) ? 1 : cycles;
    endfunction

    function automatic logic [DIV_W-1:0] rate_last(input logic [1:0] sel);
        logic [31:0] period;
        period = 32'd1 << RATE_LOG2[sel];
        return DIV_W'(period - 32'd1);
    endfunction

endpackage

// File: rtl/step_controller_key_debounce.sv
// key_debounce
//   Synchronises the raw active-low push button and debounces it.
//   Ports:
//     clk, reset   : system clock, asynchronous active-high reset
//     key_n        : raw button, active low, asynchronous to clk
//     key_level    : debounced level, 1 = pressed (registered)
//     press        : one-cycle pulse when key_level rises (registered)
//     state        : current debounce FSM state, for debug visibility
//   Handshake: none; press is a plain single-cycle strobe with no back-pressure.
module key_debounce
    import step_controller_pkg::*;
#(
    parameter int DB_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_n,
    output logic       key_level,
    output logic       press,
    output logic [1:0] state
);

    localparam int DBC_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DBC_W-1:0] CNT_LAST = DBC_W'(DB_CYCLES - 1);

    // The synchroniser carries the inverted key so that its reset value of 0
    // reads as "not pressed" rather than a phantom press after reset.
    logic sync1_q, sync2_q;
    logic pressed;

    db_state_t        state_q, state_d;
    logic [DBC_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;

    assign pressed = sync2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + DBC_W'(1);
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_d = REL_WAIT;
                    cnt_d   = '0;
                end
            end
            REL_WAIT: begin
                // A bounce back to pressed returns to HELD without touching the level.
                if (pressed) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + DBC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= ~key_n;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign key_level = level_q;
    assign press     = press_q;
    assign state     = state_q;

endmodule

// File: rtl/step_controller.sv
// step_controller
//   Clock-enable source for the monocycle core. Produces single-cycle step_en
//   strobes either from debounced button presses (run=0) or from a free-running
//   divider (run=1), and counts retired steps.
//   Optional feature macro: STEP_CONTROLLER_BREAKPOINT_EN (free-run halts when pc==bp_addr).
//   Ports:
//     clk, reset : 50 MHz clock, asynchronous active-high reset
//     key_n      : raw push button, active low
//     run        : 1 = free-run, 0 = manual step (asynchronous switch)
//     rate_sel   : free-run period 00=2^24, 01=2^20, 10=2^16, 11=2^4 cycles
//     pc,bp_addr : breakpoint compare inputs (ignored without the feature macro)
//     step_en    : one-cycle advance strobe (registered)
//     key_level  : debounced button level, 1 = pressed
//     step_cnt   : step_en pulses since reset, wrapping
//     halted     : free-run stopped at the breakpoint
//     db_state   : debounce FSM state, for debug visibility
//   Handshake: step_en is a fire-and-forget strobe; the core has no ready path.
module step_controller
    import step_controller_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_MS = 10,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_n,
    input  logic             run,
    input  logic [1:0]       rate_sel,
    input  logic [31:0]      pc,
    input  logic [31:0]      bp_addr,
    output logic             step_en,
    output logic             key_level,
    output logic [CNT_W-1:0] step_cnt,
    output logic             halted,
    output logic [1:0]       db_state
);

    localparam int DB_CYCLES = db_cycles(CLK_HZ, DEBOUNCE_MS);

    logic             press;
    logic             run_s1_q, run_s2_q;
    logic [DIV_W-1:0] div_q, div_d, div_last;
    logic             step_en_q, step_en_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic             running, due, manual_ok, bp_hit;
`ifdef STEP_CONTROLLER_BREAKPOINT_EN
    logic             halted_q, halted_d;
    logic             stepped_q, stepped_d;
`else
    logic             unused_bp;
    assign unused_bp = ^{pc, bp_addr};
`endif

    key_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_key_debounce (
        .clk       (clk),
        .reset     (reset),
        .key_n     (key_n),
        .key_level (key_level),
        .press     (press),
        .state     (db_state)
    );

    always_comb begin
        div_last = rate_last(rate_sel);
`ifdef STEP_CONTROLLER_BREAKPOINT_EN
        bp_hit    = (pc == bp_addr);
        running   = run_s2_q && !halted_q;
        manual_ok = !run_s2_q || halted_q;
`else
        bp_hit    = 1'b0;
        running   = run_s2_q;
        manual_ok = !run_s2_q;
`endif
        // ">=" rather than "==" so a switch to a shorter period while the
        // divider is already past its end fires on the next cycle.
        due        = running && (div_q >= div_last);
        div_d      = (running && !due) ? div_q + DIV_W'(1) : '0;
        step_en_d  = (press && manual_ok) || (due && !bp_hit);
        step_cnt_d = step_cnt_q + CNT_W'(step_en_q);
`ifdef STEP_CONTROLLER_BREAKPOINT_EN
        halted_d  = halted_q;
        stepped_d = stepped_q;
        if (!run_s2_q) begin
            halted_d  = 1'b0;
            stepped_d = 1'b0;
        end else if (halted_q) begin
            // Leave the halt only once a manual step has happened and pc has moved off the breakpoint.
            if (step_en_q) begin
                stepped_d = 1'b1;
            end
            if (stepped_q && !bp_hit) begin
                halted_d  = 1'b0;
                stepped_d = 1'b0;
            end
        end else if (due && bp_hit) begin
            halted_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_s1_q   <= 1'b0;
            run_s2_q   <= 1'b0;
            div_q      <= '0;
            step_en_q  <= 1'b0;
            step_cnt_q <= '0;
`ifdef STEP_CONTROLLER_BREAKPOINT_EN
            halted_q   <= 1'b0;
            stepped_q  <= 1'b0;
`endif
        end else begin
            run_s1_q   <= run;
            run_s2_q   <= run_s1_q;
            div_q      <= div_d;
            step_en_q  <= step_en_d;
            step_cnt_q <= step_cnt_d;
`ifdef STEP_CONTROLLER_BREAKPOINT_EN
            halted_q   <= halted_d;
            stepped_q  <= stepped_d;
`endif
        end
    end

    assign step_en  = step_en_q;
    assign step_cnt = step_cnt_q;
`ifdef STEP_CONTROLLER_BREAKPOINT_EN
    assign halted   = halted_q;
`else
    assign halted   = 1'b0;
`endif

endmodule

// File: tb/tb_step_controller.sv
// tb_step_controller
//   Directed scenarios plus randomized stimulus, checked every cycle against a
//   behavioural model. The counter is instantiated 8 bits wide so the wrap is
//   reachable in a short run.
module tb_step_controller;

    localparam int CLK_HZ      = 1000;
    localparam int DEBOUNCE_MS = 4;
    localparam int CNT_W       = 8;
    localparam int DB          = 4;
`ifdef STEP_CONTROLLER_BREAKPOINT_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic             key_n;
    logic             run;
    logic [1:0]       rate_sel;
    logic [31:0]      pc;
    logic [31:0]      bp_addr;
    logic             step_en;
    logic             key_level;
    logic [CNT_W-1:0] step_cnt;
    logic             halted;
    logic [1:0]       db_state;

    int tests_run    = 0;
    int tests_failed = 0;
    int pulse_cnt    = 0;

    step_controller #(
        .CLK_HZ      (CLK_HZ),
        .DEBOUNCE_MS (DEBOUNCE_MS),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key_n     (key_n),
        .run       (run),
        .rate_sel  (rate_sel),
        .pc        (pc),
        .bp_addr   (bp_addr),
        .step_en   (step_en),
        .key_level (key_level),
        .step_cnt  (step_cnt),
        .halted    (halted),
        .db_state  (db_state)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Inputs pass through two-sample delay lines. The debounced level follows the
    // synchronised key once it has disagreed with the level for DB+1 consecutive
    // samples. Free-run fires once per period, counted from the cycle run is seen.
    bit [1:0]          m_kp, m_rp;
    bit                m_lvl, m_press, m_step, m_halt, m_stepped;
    int                m_run;
    int unsigned       m_div;
    logic [CNT_W-1:0]  m_cnt;

    function automatic int unsigned period_of(input logic [1:0] sel);
        case (sel)
            2'd0:    return 32'd1 << 24;
            2'd1:    return 32'd1 << 20;
            2'd2:    return 32'd1 << 16;
            default: return 32'd16;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_kp = '0; m_rp = '0; m_lvl = 0; m_press = 0; m_step = 0;
            m_halt = 0; m_stepped = 0; m_run = 0; m_div = 0; m_cnt = '0;
        end else begin
            bit key_s, run_s, p_old, s_old, h_old, running, due, hit;
            key_s = m_kp[1];
            run_s = m_rp[1];
            p_old = m_press;
            s_old = m_step;
            h_old = m_halt;
            m_press = 1'b0;
            if (key_s != m_lvl) begin
                m_run++;
                if (m_run == DB + 1) begin
                    m_lvl   = key_s;
                    m_run   = 0;
                    m_press = key_s;
                end
            end else begin
                m_run = 0;
            end
            hit     = BP_EN && (pc == bp_addr);
            running = run_s && !h_old;
            due     = running && (m_div >= period_of(rate_sel) - 1);
            m_step  = (p_old && (!run_s || h_old)) || (due && !hit);
            m_div   = (!running || due) ? 0 : m_div + 1;
            if (!run_s) begin
                m_halt = 0; m_stepped = 0;
            end else if (h_old) begin
                if (m_stepped && !hit) begin
                    m_halt = 0; m_stepped = 0;
                end else if (s_old) begin
                    m_stepped = 1;
                end
            end else if (due && hit) begin
                m_halt = 1;
            end
            m_cnt = m_cnt + CNT_W'(s_old);
            m_kp  = {m_kp[0], ~key_n};
            m_rp  = {m_rp[0], run};
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!reset) begin
            check("step_en", {31'd0, step_en}, {31'd0, m_step});
            check("key_level", {31'd0, key_level}, {31'd0, m_lvl});
            check("step_cnt", {24'd0, step_cnt}, {24'd0, m_cnt});
            check("halted", {31'd0, halted}, {31'd0, m_halt});
        end
    end

    // Counts each step_en cycle one edge later, away from the driver's negedge.
    always @(posedge clk) begin
        if (!reset && step_en) pulse_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_key(input int hold, input int gap);
        key_n = 1'b0;
        tick(hold);
        key_n = 1'b1;
        tick(gap);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int n;
        reset = 1'b1; key_n = 1'b1; run = 1'b0; rate_sel = 2'd3;
        pc = 32'h20; bp_addr = 32'h10;
        tick(3);
        check("reset_step_en", {31'd0, step_en}, 32'd0);
        check("reset_key_level", {31'd0, key_level}, 32'd0);
        check("reset_step_cnt", {24'd0, step_cnt}, 32'd0);
        check("reset_halted", {31'd0, halted}, 32'd0);
        check("reset_db_state", {30'd0, db_state}, 32'd0);
        reset = 1'b0;
        tick(2);

        // short press is a glitch
        key_n = 1'b0; tick(3); key_n = 1'b1; tick(20);
        check("glitch_key_level", {31'd0, key_level}, 32'd0);
        check("glitch_step_cnt", {24'd0, step_cnt}, 32'd0);

        // long press gives one step; level rises 6 edges after the first low sample
        pulse_cnt = 0; key_n = 1'b0; lat = -1;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            tick(1);
            if (key_level) lat = k - 1;
        end
        check("key_level_latency", lat, 32'd6);
        tick(50 - 7);
        key_n = 1'b1;
        tick(20);
        check("manual_pulses", pulse_cnt, 32'd1);
        check("manual_step_cnt", {24'd0, step_cnt}, 32'd1);
        check("manual_release", {31'd0, key_level}, 32'd0);

        // free-run at 16-cycle period
        pulse_cnt = 0; run = 1'b1; rate_sel = 2'd3;
        tick(72);
        run = 1'b0;
        check("freerun_pulses", pulse_cnt, 32'd4);
        tick(10);
        check("freerun_step_cnt", {24'd0, step_cnt}, 32'd5);
        // a cleared divider means a full 2+16 cycles to the first pulse
        run = 1'b1; lat = -1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            tick(1);
            if (step_en) lat = k;
        end
        check("rerun_first_pulse", lat, 32'd18);
        run = 1'b0;
        tick(10);

        // async reset in the middle of PRESS_WAIT
        key_n = 1'b0;
        tick(4);
        check("pw_state", {30'd0, db_state}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_step_en", {31'd0, step_en}, 32'd0);
        check("async_key_level", {31'd0, key_level}, 32'd0);
        check("async_step_cnt", {24'd0, step_cnt}, 32'd0);
        check("async_db_state", {30'd0, db_state}, 32'd0);
        @(negedge clk);
        key_n = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);

`ifdef STEP_CONTROLLER_BREAKPOINT_EN
        pc = 32'h10; bp_addr = 32'h10; run = 1'b1; rate_sel = 2'd3; pulse_cnt = 0;
        tick(40);
        check("bp_halted", {31'd0, halted}, 32'd1);
        check("bp_no_pulse", pulse_cnt, 32'd0);
        press_key(20, 15);
        check("bp_manual_step", pulse_cnt, 32'd1);
        check("bp_still_halted", {31'd0, halted}, 32'd1);
        pc = 32'h20;
        tick(2);
        check("bp_released", {31'd0, halted}, 32'd0);
        pulse_cnt = 0;
        tick(40);
        check("bp_resumed", {31'd0, pulse_cnt >= 2}, 32'd1);
        run = 1'b0;
        tick(5);
`endif

        // randomized stimulus
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0: press_key($urandom_range(1, 12), $urandom_range(1, 12));
                1: begin run = ~run; tick($urandom_range(1, 30)); end
                2: begin
                    if ($urandom_range(0, 3) == 0) rate_sel = 2'($urandom_range(0, 1));
                    else rate_sel = 2'($urandom_range(2, 3));
                    tick($urandom_range(1, 30));
                end
                3: tick($urandom_range(1, 40));
                default: begin
                    pc = ($urandom_range(0, 1) == 1) ? bp_addr : 32'h20;
                    tick($urandom_range(1, 20));
                end
            endcase
        end
        key_n = 1'b1;

        // counter wrap
        run = 1'b0; pc = 32'h20;
        tick(5);
        run = 1'b1; rate_sel = 2'd3;
        n = 0;
        while (step_cnt != 8'hFF && n < 6000) begin tick(1); n++; end
        check("wrap_reach_ff", {24'd0, step_cnt}, 32'hFF);
        n = 0;
        while (!step_en && n < 40) begin tick(1); n++; end
        check("wrap_pulse_seen", {31'd0, step_en}, 32'd1);
        tick(1);
        check("step_cnt_wrap", {24'd0, step_cnt}, 32'd0);
        run = 1'b0;
        tick(5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
